uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
- Transmit-side frame engine of the UART.
- Captures a parallel byte on a write strobe and builds an 11-bit serial frame: start, data, parity/stop bits, stop.
- Generates the bit-time pulse (btu) and the frame-active enable (doit) that drive the downstream bit counter, and shifts the frame out LSB-first.
- Returns to idle when the bit counter reports done; the CPU-side write logic polls txrdy.

Parameters:
- BAUD_W, 19, width of the baud divisor input and the internal bit-time counter.
- FRAME_W, 11, serial frame length in bits; fixed by the frame format, not to be overridden.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- baud_k  input  BAUD_W  clocks per bit time; 0 and 1 both mean one clock per bit.
- load  input  1  write strobe; one-cycle pulse, accepted only when txrdy=1.
- data_in  input  8  byte to transmit, sampled on an accepted load.
- eight  input  1  1 = 8 data bits; 0 = 7 data bits.
- pen  input  1  parity enable.
- ohel  input  1  parity sense: 0 = even, 1 = odd.
- done  input  1  from the bit counter; high once 11 btu pulses have been counted in the current frame.
- tx  output  1  serial line, idle high.
- txrdy  output  1  high when idle and able to accept load.
- btu  output  1  one-cycle bit-time pulse; only asserted while doit=1.
- doit  output  1  high for the whole frame; enables the bit counter.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, tx = 1, txrdy = 1, doit = 0, btu = 0.
  - Baud counter = 0; shift register = all ones.
- Reset mid-frame aborts the frame immediately. tx returns to 1 on the next edge.
- FSM states:
  - IDLE: txrdy=1, doit=0. Transition to SHIFT when load=1. On that edge, load the frame, clear txrdy, set doit.
  - SHIFT: txrdy=0, doit=1. Baud counter increments each clock. When count = baud_k-1, or baud_k<=1: btu=1 for that cycle, the counter clears, and the shift register shifts right with a 1 filled in at the MSB.
  - SHIFT exits when done=1. Transition to IDLE on the next edge: doit=0, txrdy=1, baud counter cleared.
- tx is always shift register bit 0, registered. A load accepted at edge t drives tx=0 (start bit) from t+1.
- Frame, LSB first: bit0 = 0 (start), bits1-7 = data_in[6:0], bit8 = b7, bit9 = b8, bit10 = 1 (stop).
- b7 and b8 by mode:
  - eight=1: b7 = data_in[7]; b8 = parity if pen=1, else 1.
  - eight=0: b7 = parity if pen=1, else 1; b8 = 1.
- Parity is computed over the active data bits only (7 or 8).
  - Even (ohel=0): parity = XOR of the data bits.
  - Odd (ohel=1): parity = XNOR of the data bits.
- Each bit lasts max(baud_k,1) clocks. Frame length = 11 bit times + 1 clock for done detection.
- eight, pen, ohel and data_in are sampled only at load acceptance. Changes mid-frame have no effect.
- baud_k is sampled continuously. A change mid-frame takes effect at the next compare.
- load while txrdy=0 is ignored. The in-flight frame is unaffected.
- load on the same edge that SHIFT→IDLE occurs is ignored, because txrdy is still 0 that cycle.
- done=1 while in IDLE is ignored.
- Baud counter wrap: the counter never exceeds baud_k-1. If baud_k is lowered below the current count, the count clears and btu pulses on the next cycle.

Optional Feature:
- Macro: UART_TX_OVERRUN_EN.
- When defined:
  - Adds output ovr (1 bit, reset 0) and input ovr_clr (1 bit).
  - ovr is set on any load with txrdy=0 and stays set until ovr_clr=1.
  - Set and clear in the same cycle: set wins.
- When undefined: neither port exists; ignored loads are silent.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE, SHIFT).
  - FRAME_W = 11.
  - Parity constants PAR_EVEN = 0, PAR_ODD = 1.
  - A frame-build function from (data, eight, pen, ohel) to the 11-bit frame.
- One sub-module: uart_baud_gen (baud counter plus btu compare, enabled by doit). The FSM and shift register stay in the top.

Test Plan:
- Reset, then baud_k=4, eight=1, pen=0, load data_in=8'hA5 -> tx start bit 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1, then 1,1; txrdy high again 45 clocks after load (paired with the bit counter model).
- eight=1, pen=1, ohel=0, data_in=8'h07 -> parity bit9 = 1; ohel=1 -> bit9 = 0; bit10 = 1 in both.
- eight=0, pen=1, ohel=0, data_in=8'hFF -> bits1-7 all 1, bit8 = 1 (parity over 7 bits), bit9 = 1.
- baud_k=0, then 1 -> btu asserted every SHIFT cycle; frame completes in 12 clocks.
- load pulsed mid-frame with data_in=8'h00 -> serial output unchanged from the original byte; with UART_TX_OVERRUN_EN, ovr=1 until ovr_clr.
- reset asserted at bit 5 -> next clock tx=1, txrdy=1, doit=0; a following load of 8'h3C transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit engine: FSM encoding,
// frame geometry, parity sense constants and the frame builder.
package uart_pkg;

  localparam int FRAME_W = 11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  // Frame is returned LSB-first: start, data[6:0], b7, b8, stop.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [7:0] data,
    input logic       eight,
    input logic       pen,
    input logic       ohel
  );
    logic par;
    logic b7;
    logic b8;
    par = (eight ? ^data : ^data[6:0]) ^ (ohel == PAR_ODD);
    if (eight) begin
      b7 = data[7];
      b8 = pen ? par : 1'b1;
    end else begin
      b7 = pen ? par : 1'b1;
      b8 = 1'b1;
    end
    return {1'b1, b8, b7, data[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Handshake/config bundle between the CPU-side write logic, the bit counter
// and the transmit engine. UART_TX_OVERRUN_EN adds the ovr/ovr_clr pair.
interface uart_tx_engine_if #(
  parameter int BAUD_W = 19
);

  logic [BAUD_W-1:0] baud_k;
  logic              load;
  logic [7:0]        data_in;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic              done;
  logic              tx;
  logic              txrdy;
  logic              btu;
  logic              doit;
`ifdef UART_TX_OVERRUN_EN
  logic              ovr;
  logic              ovr_clr;

  modport master (
    output baud_k, load, data_in, eight, pen, ohel, done, ovr_clr,
    input  tx, txrdy, btu, doit, ovr
  );

  modport slave (
    input  baud_k, load, data_in, eight, pen, ohel, done, ovr_clr,
    output tx, txrdy, btu, doit, ovr
  );
`else
  modport master (
    output baud_k, load, data_in, eight, pen, ohel, done,
    input  tx, txrdy, btu, doit
  );

  modport slave (
    input  baud_k, load, data_in, eight, pen, ohel, done,
    output tx, txrdy, btu, doit
  );
`endif

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time generator: counts clocks while enabled and pulses btu once per
// bit time; baud_k of 0 or 1 yields a pulse every enabled cycle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              btu
);

  logic [BAUD_W-1:0] r_cnt;
  logic              w_hit;

  // >= rather than == so a baud_k lowered below the running count wraps at once.
  assign w_hit = (baud_k <= BAUD_W'(1)) || (r_cnt >= baud_k - BAUD_W'(1));
  assign btu   = en && w_hit;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (reset || !en) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit frame engine: IDLE/SHIFT FSM, frame shift register and
// bit-time generator. Define UART_TX_OVERRUN_EN to flag loads made while busy.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_engine_if.slave  bus
);

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic               w_accept;
  logic               w_exit;
  logic               w_txrdy;
  logic               w_doit;
  logic               w_btu;
  logic [FRAME_W-1:0] r_shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exit      = 1'b0;
    w_txrdy     = 1'b0;
    w_doit      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_txrdy = 1'b1;
        if (bus.load) begin
          w_state_nxt = SHIFT;
          w_accept    = 1'b1;
        end
      end
      SHIFT: begin
        w_doit = 1'b1;
        if (bus.done) begin
          w_state_nxt = IDLE;
          w_exit      = 1'b1;
        end
      end
    endcase
  end

  uart_baud_gen #(
    .BAUD_W (BAUD_W)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (w_doit),
    .baud_k (bus.baud_k),
    .btu    (w_btu)
  );

  always_ff @(posedge clk) begin
    // NOTE: reset to all ones so the line idles high; this is a plain register, not a memory.
    if (reset) begin
      r_shreg <= '1;
    end else if (w_accept) begin
      r_shreg <= build_frame(bus.data_in, bus.eight, bus.pen, bus.ohel);
    end else if (w_exit) begin
      r_shreg <= '1;
    end else if (w_btu) begin
      r_shreg <= {1'b1, r_shreg[FRAME_W-1:1]};
    end
  end

  assign bus.tx    = r_shreg[0];
  assign bus.txrdy = w_txrdy;
  assign bus.doit  = w_doit;
  assign bus.btu   = w_btu;

`ifdef UART_TX_OVERRUN_EN
  logic r_ovr;

  // Set has priority over clear so a rejected load is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr <= 1'b0;
    end else if (bus.load && !w_txrdy) begin
      r_ovr <= 1'b1;
    end else if (bus.ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign bus.ovr = r_ovr;
`endif

endmodule
